fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the fetch stage when instruction memory has variable latency. It issues one request per instruction and holds the program counter via StallF until the word returns. It delivers the word and its PC to decode through a registered output with a one-entry skid buffer, and discards in-flight responses when the execute stage redirects the PC. It sits between the Program_Counter/PC mux and the instruction memory, and is the only source of StallF.

## Interface
- RESET_NOP, 32'h00000013, InstrD value at reset and after flush
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCF  in  32  current Program_Counter output
- RedirectE  in  1  taken branch/jump; PC mux selects PC_Updated_CHU this cycle
- StallD  in  1  decode cannot accept a new instruction this cycle
- imem_req  out  1  single-cycle request pulse; address sampled by memory on this edge
- imem_addr  out  32  request address, equals PCF
- imem_ack  in  1  single-cycle response strobe, at least 1 cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_ack
- StallF  out  1  1 = Program_Counter holds; 0 = PC loads mux output
- InstrD  out  32  registered instruction to decode
- PCD  out  32  registered PC of InstrD
- InstrValidD  out  1  InstrD/PCD hold a live instruction

## Operation
- State machine states: IDLE, WAIT, HOLD, DROP. Reset state: IDLE.
- Registers: req_pc (32), skid_instr (32), skid_pc (32), output registers InstrD/PCD/InstrValidD.
- IDLE:
  - If RedirectE=0: imem_req=1, imem_addr=PCF, req_pc<=PCF, go to WAIT.
  - If RedirectE=1: no request, stay in IDLE.
- WAIT with no ack: stay in WAIT. With RedirectE=1 and no ack: go to DROP.
- WAIT with imem_ack=1:
  - RedirectE=1: discard the response, go to IDLE.
  - Else if StallD=0: InstrD<=imem_rdata, PCD<=req_pc, InstrValidD<=1, go to IDLE.
  - Else: skid<=(imem_rdata, req_pc), go to HOLD.
- HOLD:
  - RedirectE=1: discard the skid buffer, go to IDLE.
  - Else if StallD=0: output registers <= skid, InstrValidD<=1, go to IDLE.
  - Else: stay in HOLD.
- DROP: ignore imem_rdata. On imem_ack go to IDLE. A repeated RedirectE stays in DROP.
- StallF=0 exactly when any of these holds:
  - RedirectE=1;
  - WAIT & imem_ack & !StallD;
  - HOLD & !StallD.
  Otherwise StallF=1, so the PC advances to PC+4 on the same edge the instruction is delivered.
- Output registers:
  - RedirectE=1: InstrD<=RESET_NOP and InstrValidD<=0. Flush beats StallD.
  - Else StallD=1 with no delivery: InstrD, PCD and InstrValidD hold.
  - Else StallD=0 with no delivery: InstrValidD<=0 (bubble) and InstrD<=RESET_NOP.
- imem_req and StallF are combinational from state and inputs. During reset: imem_req=0 and StallF=1.

## Timing
- Reset values: state=IDLE, InstrD=RESET_NOP, PCD=0, InstrValidD=0, req_pc and skid=0.
- With 1-cycle memory and no stalls, the sequence per instruction is 2 cycles: req in IDLE, ack in WAIT. InstrValidD rises the cycle after ack.
- Max throughput: one instruction per 2 cycles. There is never more than one outstanding request.
- An ack arriving in IDLE or HOLD is a protocol error. It is ignored and the bench flags it.
- When reset is asserted mid-request, state returns to IDLE and the late ack is treated as stray.
  - The memory model must also be reset so it does not return that ack.

## Test plan
- Straight-line fetch:
  - Stimulus: reset, then PCF=0x0, memory latency 1, StallD=0.
  - Response: req at PC 0x0, 0x4, 0x8. InstrD/PCD follow each ack by 1 cycle, InstrValidD pulses. StallF low only in the ack cycles.
- Long latency:
  - Stimulus: ack 5 cycles after req.
  - Response: StallF=1 for all 5 cycles and PCF unchanged. Delivery has PCD=req address.
- Decode stall:
  - Stimulus: StallD=1 from 1 cycle before ack for 3 cycles.
  - Response: state HOLD, InstrD unchanged during the stall. Skid word delivered the cycle StallD falls. StallF=0 only that cycle.
- Redirect in WAIT:
  - Stimulus: RedirectE=1 with target 0x100 two cycles after req to 0x8.
  - Response: StallF=0 that cycle, InstrValidD=0 next. The 0x8 response is dropped. Next req has imem_addr=0x100.
- Redirect coincident with ack:
  - Response: rdata discarded, IDLE next, req for the target. No InstrValidD=1 for the old PC.
- Synchronous reset while in WAIT:
  - Response: all outputs at reset values on the next edge, and imem_req=0 while reset is high.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch-stage sequencer for a variable-latency instruction memory.
//            Issues one request per instruction, stalls the PC until the word
//            returns, delivers word and PC to decode via registered outputs
//            with a one-entry skid buffer, and drops in-flight responses on
//            an execute-stage redirect.
// Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_NOP = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        RedirectE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        StallF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic        InstrValidD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic        valid_q, valid_d;

    // Delivery of a word to decode on this edge, and where it comes from
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    // The memory always sees the live PC; imem_req qualifies it
    assign imem_addr = PCF;

    // Next-state, request strobe and delivery selection
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        imem_req      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = req_pc_q;

        case (state_q)
            IDLE: begin
                if (!RedirectE) begin
                    imem_req = 1'b1;
                    req_pc_d = PCF;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (RedirectE) begin
                        state_d = IDLE;
                    end else if (!StallD) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = req_pc_q;
                        state_d      = HOLD;
                    end
                end else if (RedirectE) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                // Any ack seen here is a stray response and is ignored
                if (RedirectE) begin
                    state_d = IDLE;
                end else if (!StallD) begin
                    deliver       = 1'b1;
                    deliver_instr = skid_instr_q;
                    deliver_pc    = skid_pc_q;
                    state_d       = IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            imem_req = 1'b0;
        end
    end

    // PC may advance on a redirect or on the edge that hands a word to decode
    assign StallF = reset
                  | ~( RedirectE
                     | ((state_q == WAIT) & imem_ack & ~StallD)
                     | ((state_q == HOLD) & ~StallD) );

    // Decode-facing output registers: flush beats stall, stall holds, idle bubbles
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;
        if (RedirectE) begin
            instr_d = RESET_NOP;
            valid_d = 1'b0;
        end else if (deliver) begin
            instr_d = deliver_instr;
            pcd_d   = deliver_pc;
            valid_d = 1'b1;
        end else if (!StallD) begin
            instr_d = RESET_NOP;
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_pc_q     <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            instr_q      <= RESET_NOP;
            pcd_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            valid_q      <= valid_d;
        end
    end

    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign InstrValidD = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl: PC model, variable-latency
//            memory model and an in-order scoreboard of expected deliveries.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] pcf;
    logic        RedirectE;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        StallF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        InstrValidD;

    logic [31:0] target;
    int          lat;
    int          n_checks;
    int          n_errors;
    int          n_deliv;

    fetch_ctrl #(.RESET_NOP(C_NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (pcf),
        .RedirectE   (RedirectE),
        .StallD      (StallD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .StallF      (StallF),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .InstrValidD (InstrValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Program counter: holds on StallF, loads target on redirect, else +4
    always @(posedge clk) begin
        if (reset)          pcf <= 32'd0;
        else if (!StallF)   pcf <= RedirectE ? target : pcf + 32'd4;
    end

    // Memory: one outstanding request, ack 'lat' cycles after the request
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    assign imem_ack   = mem_busy && (mem_cnt == 0);
    assign imem_rdata = mem_busy ? word_of(mem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (reset) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= 32'd0;
        end else if (imem_req) begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 1;
            mem_addr <= imem_addr;
        end else if (imem_ack) begin
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            mem_cnt  <= mem_cnt - 1;
        end
    end

    // Scoreboard: push on request, flush on redirect/reset, pop on fresh delivery
    logic [63:0] sb_q[$];
    logic        held;
    always @(negedge clk) begin
        logic [63:0] e;
        if (InstrValidD && !held) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", 32'(InstrValidD), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_pcd", PCD, e[63:32]);
                check_eq("sb_instr", InstrD, e[31:0]);
                n_deliv <= n_deliv + 1;
            end
        end
        if (reset || RedirectE) begin
            sb_q.delete();
            held <= 1'b0;
        end else begin
            held <= InstrValidD && StallD;
            if (imem_req) begin
                check_eq("req_addr", imem_addr, pcf);
                sb_q.push_back({imem_addr, word_of(imem_addr)});
            end
        end
    end

    task automatic wait_req(output logic [31:0] addr);
        bit seen = 0;
        addr = 32'd0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (imem_req) begin
                seen = 1;
                addr = imem_addr;
            end
        end
        if (!seen) check_eq("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_deliv(input int n);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            if (n_deliv >= n) done = 1;
        end
        if (!done) check_eq("deliv_timeout", 32'(n_deliv), 32'(n));
        #1;
    endtask

    logic [31:0] ra;
    logic [31:0] pc0;
    logic [31:0] saved;
    int          nd;

    initial begin
        n_checks = 0; n_errors = 0; n_deliv = 0; held = 1'b0;
        reset = 1'b1; RedirectE = 1'b0; StallD = 1'b0; target = 32'd0; lat = 1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_instr", InstrD, C_NOP);
        check_eq("rst_pcd", PCD, 32'd0);
        check_eq("rst_valid", 32'(InstrValidD), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_stallf", 32'(StallF), 32'd1);

        // Straight-line fetch, latency 1
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("s1_req", 32'(imem_req), 32'd1);
        check_eq("s1_addr", imem_addr, 32'd0);
        check_eq("s1_stallf_req", 32'(StallF), 32'd1);
        @(negedge clk);
        check_eq("s1_ack", 32'(imem_ack), 32'd1);
        check_eq("s1_stallf_ack", 32'(StallF), 32'd0);
        @(negedge clk);
        check_eq("s1_valid", 32'(InstrValidD), 32'd1);
        check_eq("s1_pcd0", PCD, 32'd0);
        check_eq("s1_addr4", imem_addr, 32'd4);
        @(negedge clk);
        check_eq("s1_stallf_ack2", 32'(StallF), 32'd0);
        @(negedge clk);
        check_eq("s1_pcd4", PCD, 32'd4);
        wait_deliv(3);

        // Long latency: PC frozen for 5 cycles
        lat = 5;
        wait_req(ra);
        pc0 = pcf;
        for (int i = 0; i < 5; i++) begin
            check_eq("ll_stallf", 32'(StallF), 32'd1);
            check_eq("ll_pc_hold", pcf, pc0);
            @(negedge clk);
        end
        check_eq("ll_ack", 32'(imem_ack), 32'd1);
        check_eq("ll_stallf_ack", 32'(StallF), 32'd0);
        @(negedge clk);
        check_eq("ll_valid", 32'(InstrValidD), 32'd1);
        check_eq("ll_pcd", PCD, ra);

        // Decode stall across the ack: skid buffer
        @(posedge clk); #1 lat = 3;
        wait_req(ra);
        @(posedge clk);
        @(posedge clk); #1 StallD = 1'b1;
        saved = InstrD;
        @(negedge clk);
        check_eq("ds_stallf0", 32'(StallF), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("ds_ack", 32'(imem_ack), 32'd1);
        check_eq("ds_stallf1", 32'(StallF), 32'd1);
        check_eq("ds_hold1", InstrD, saved);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("ds_stallf2", 32'(StallF), 32'd1);
        check_eq("ds_hold2", InstrD, saved);
        @(posedge clk); #1 StallD = 1'b0;
        @(negedge clk);
        check_eq("ds_stallf_rel", 32'(StallF), 32'd0);
        check_eq("ds_hold3", InstrD, saved);
        @(negedge clk);
        check_eq("ds_valid", 32'(InstrValidD), 32'd1);
        check_eq("ds_pcd", PCD, ra);
        check_eq("ds_stallf_after", 32'(StallF), 32'd1);

        // Redirect while waiting: response dropped
        @(posedge clk); #1 lat = 4;
        wait_req(ra);
        @(posedge clk);
        @(posedge clk); #1 RedirectE = 1'b1; target = 32'h100;
        @(negedge clk);
        check_eq("rw_stallf", 32'(StallF), 32'd0);
        @(posedge clk); #1 RedirectE = 1'b0;
        @(negedge clk);
        check_eq("rw_valid", 32'(InstrValidD), 32'd0);
        check_eq("rw_instr", InstrD, C_NOP);
        check_eq("rw_pc", pcf, 32'h100);
        @(negedge clk);
        check_eq("rw_drop_ack", 32'(imem_ack), 32'd1);
        check_eq("rw_drop_stallf", 32'(StallF), 32'd1);
        wait_req(ra);
        check_eq("rw_new_addr", ra, 32'h100);
        nd = n_deliv;
        wait_deliv(nd + 1);

        // Redirect coincident with ack
        lat = 2;
        wait_req(ra);
        @(posedge clk);
        @(posedge clk); #1 RedirectE = 1'b1; target = 32'h200;
        @(negedge clk);
        check_eq("ra_ack", 32'(imem_ack), 32'd1);
        check_eq("ra_stallf", 32'(StallF), 32'd0);
        @(posedge clk); #1 RedirectE = 1'b0;
        @(negedge clk);
        check_eq("ra_req", 32'(imem_req), 32'd1);
        check_eq("ra_addr", imem_addr, 32'h200);
        check_eq("ra_valid", 32'(InstrValidD), 32'd0);
        nd = n_deliv;
        wait_deliv(nd + 1);
        @(negedge clk);
        check_eq("ra_pcd", PCD, 32'h200);

        // Synchronous reset in WAIT
        @(posedge clk); #1 lat = 3;
        wait_req(ra);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rr_req", 32'(imem_req), 32'd0);
        check_eq("rr_stallf", 32'(StallF), 32'd1);
        @(negedge clk);
        check_eq("rr_instr", InstrD, C_NOP);
        check_eq("rr_pcd", PCD, 32'd0);
        check_eq("rr_valid", 32'(InstrValidD), 32'd0);
        check_eq("rr_req2", 32'(imem_req), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rr_restart_req", 32'(imem_req), 32'd1);
        check_eq("rr_restart_addr", imem_addr, 32'd0);
        nd = n_deliv;
        wait_deliv(nd + 1);
        @(negedge clk);
        check_eq("rr_pcd_final", PCD, 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
